// File: rtl/freq_gate_counter_pkg.sv
// Shared defaults, state encoding and BCD digit helper for the gated frequency counter.
package freq_gate_counter_pkg;

  localparam int unsigned CNT_W_DEF     = 27;
  localparam int unsigned DIGITS_DEF    = 8;
  localparam int unsigned MAX_COUNT_DEF = 99_999_999;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    COUNT = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Double-dabble correction applied to one BCD digit before each shift
  function automatic logic [3:0] dd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/freq_gate_counter_if.sv
// Gate/signal inputs and the BCD result bus of the frequency counter.
interface freq_gate_counter_if
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF
);
  logic                  gate;
  logic                  sig_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  valid;
  logic                  ovf;
  logic                  busy;

  modport master (output gate, sig_in, input bcd_out, valid, ovf, busy);
  modport slave  (input gate, sig_in, output bcd_out, valid, ovf, busy);
endinterface

// File: rtl/freq_gate_counter_bin2bcd_seq.sv
// Iterative double-dabble: one shift per cycle, done pulses after CNT_W shifts.
module freq_gate_counter_bin2bcd_seq
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                clk_50MHz,
  input  logic                clr_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done
);

  localparam int unsigned STEP_W = $clog2(CNT_W);

  logic [CNT_W-1:0]    sh;
  logic [4*DIGITS-1:0] adj_c;
  logic [STEP_W-1:0]   step;
  logic                run;

  always_comb begin
    adj_c = bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      adj_c[4*d +: 4] = dd_adj(bcd[4*d +: 4]);
    end
  end

  // A new start always wins, so a restart mid-conversion begins again from shift 0
  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) begin
      sh   <= '0;
      bcd  <= '0;
      step <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        step <= '0;
        run  <= 1'b1;
      end else if (run) begin
        bcd <= {adj_c[4*DIGITS-2:0], sh[CNT_W-1]};
        sh  <= {sh[CNT_W-2:0], 1'b0};
        if (step == STEP_W'(CNT_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          step <= step + STEP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts sig_in rises per gate window and publishes the count as packed BCD.
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned DIGITS    = DIGITS_DEF,
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic                clk_50MHz,
  input  logic                clr_n,
  freq_gate_counter_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic                s1, s2, s3, gate_d;
  logic                sig_rise_c, gate_rise_c;
  logic [CNT_W-1:0]    cnt, bin_c;
  logic                sat_c, ovf_pend;
  state_e              state, state_n;
  logic                start_c, publish_c;
  logic [4*DIGITS-1:0] bcd;
  logic                conv_done;

  // sig_in is asynchronous; gate is already in this clock domain
  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      gate_d <= 1'b0;
    end else begin
      s1     <= bus.sig_in;
      s2     <= s1;
      s3     <= s2;
      gate_d <= bus.gate;
    end
  end

  assign sig_rise_c  = s2 & ~s3;
  assign gate_rise_c = bus.gate & ~gate_d;

  // An edge coincident with the gate edge belongs to the new window
  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (gate_rise_c) begin
      cnt <= sig_rise_c ? CNT_W'(1) : '0;
    end else if (sig_rise_c && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat_c = (cnt > MAX_C);
  assign bin_c = sat_c ? MAX_C : cnt;

  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) state <= ARM;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_c   = 1'b0;
    publish_c = 1'b0;
    case (state)
      ARM:   if (gate_rise_c) state_n = COUNT;
      COUNT: if (gate_rise_c) begin
               state_n = CONV;
               start_c = 1'b1;
             end
      CONV:  if (gate_rise_c)    start_c = 1'b1;
             else if (conv_done) state_n = DONE;
      DONE:  if (gate_rise_c) begin
               state_n = CONV;
               start_c = 1'b1;
             end else begin
               state_n   = COUNT;
               publish_c = 1'b1;
             end
      default: state_n = ARM;
    endcase
  end

  freq_gate_counter_bin2bcd_seq #(
    .CNT_W  (CNT_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk_50MHz (clk_50MHz),
    .clr_n     (clr_n),
    .start     (start_c),
    .bin       (bin_c),
    .bcd       (bcd),
    .done      (conv_done)
  );

  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) begin
      ovf_pend    <= 1'b0;
      bus.bcd_out <= '0;
      bus.valid   <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      if (start_c) ovf_pend <= sat_c;
      bus.valid <= publish_c;
      bus.busy  <= (state_n == CONV) || (state_n == DONE);
      if (publish_c) begin
        bus.bcd_out <= bcd;
        bus.ovf     <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench: default instance (latency 29) plus a CNT_W=12 / MAX_COUNT=999 instance for clamping.
module tb_freq_gate_counter;

  logic clk_50MHz;
  logic clr_n;
  logic g, s;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   va_cnt   = 0;
  int   va0;

  freq_gate_counter_if #(.DIGITS(8)) ifa ();
  freq_gate_counter_if #(.DIGITS(8)) ifb ();

  assign ifa.gate   = g;
  assign ifa.sig_in = s;
  assign ifb.gate   = g;
  assign ifb.sig_in = s;

  freq_gate_counter dut_a (
    .clk_50MHz (clk_50MHz),
    .clr_n     (clr_n),
    .bus       (ifa.slave)
  );

  freq_gate_counter #(.CNT_W(12), .DIGITS(8), .MAX_COUNT(999)) dut_b (
    .clk_50MHz (clk_50MHz),
    .clr_n     (clr_n),
    .bus       (ifb.slave)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) if (ifa.valid === 1'b1) va_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      s = 1'b1;
      cycles(hi);
      s = 1'b0;
      cycles(lo);
    end
  endtask

  // Called right after raising g; waits for the selected instance's strobe
  task automatic expect_result(input bit sel, input logic [31:0] exp_bcd, input logic exp_ovf,
                               input int exp_lat, input string tag);
    int   lat;
    logic busy_mid;
    lat      = -1;
    busy_mid = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk_50MHz);
      if (k == 3) busy_mid = sel ? ifb.busy : ifa.busy;
      if ((sel ? ifb.valid : ifa.valid) === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy_mid), 64'(1));
    chk({tag, "_bcd"}, 64'(sel ? ifb.bcd_out : ifa.bcd_out), 64'(exp_bcd));
    chk({tag, "_ovf"}, 64'(sel ? ifb.ovf : ifa.ovf), 64'(exp_ovf));
  endtask

  initial begin
    clr_n = 1'b0;
    g     = 1'b0;
    s     = 1'b0;
    repeat (10) begin
      @(negedge clk_50MHz);
      g = ~g;
      s = ~s;
    end
    @(negedge clk_50MHz);
    chk("rst_bcd",   64'(ifa.bcd_out), 64'(0));
    chk("rst_valid", 64'(ifa.valid),   64'(0));
    chk("rst_ovf",   64'(ifa.ovf),     64'(0));
    chk("rst_busy",  64'(ifa.busy),    64'(0));
    chk("rst_bcd_b", 64'(ifb.bcd_out), 64'(0));
    g = 1'b0;
    s = 1'b0;
    @(negedge clk_50MHz);
    clr_n = 1'b1;
    cycles(3);

    // First gate edge only arms; second one yields 100 edges (period 20)
    g = 1'b1;
    cycles(40);
    chk("arm_no_valid", 64'(va_cnt), 64'(0));
    g = 1'b0;
    pulses(100, 10, 10);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0100, 1'b0, 29, "first_window");

    g = 1'b0;
    pulses(12345, 1, 2);
    g = 1'b1;
    expect_result(1'b0, 32'h0001_2345, 1'b0, 29, "exact_12345");

    // Sixth edge lands on the gate edge: old window 5, new window 1+7
    g = 1'b0;
    pulses(5, 4, 4);
    s = 1'b1;
    cycles(2);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0005, 1'b0, 29, "coinc_old");
    s = 1'b0;
    g = 1'b0;
    cycles(3);
    pulses(7, 4, 4);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0008, 1'b0, 29, "coinc_new");

    // Second gate edge 10 cycles into CONV drops the 20-edge result
    g = 1'b0;
    pulses(20, 4, 4);
    va0 = va_cnt;
    g = 1'b1;
    pulses(2, 2, 2);
    g = 1'b0;
    cycles(2);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0002, 1'b0, 29, "restart");
    cycles(40);
    chk("restart_one_valid", 64'(va_cnt - va0), 64'(1));

    // Reset in the middle of a conversion
    g = 1'b0;
    pulses(3, 4, 4);
    g = 1'b1;
    cycles(10);
    chk("midconv_busy", 64'(ifa.busy), 64'(1));
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_bcd",   64'(ifa.bcd_out), 64'(0));
    chk("midrst_valid", 64'(ifa.valid),   64'(0));
    chk("midrst_ovf",   64'(ifa.ovf),     64'(0));
    chk("midrst_busy",  64'(ifa.busy),    64'(0));
    chk("midrst_bcd_b", 64'(ifb.bcd_out), 64'(0));
    g = 1'b0;
    s = 1'b0;
    @(negedge clk_50MHz);
    clr_n = 1'b1;
    cycles(3);
    va0 = va_cnt;
    g = 1'b1;
    cycles(40);
    chk("rearm_no_valid", 64'(va_cnt - va0), 64'(0));
    g = 1'b0;
    pulses(7, 3, 3);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0007, 1'b0, 29, "after_rst");

    // sig_in goes high and stays there: one edge, then an empty window
    g = 1'b0;
    s = 1'b1;
    cycles(50);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0001, 1'b0, 29, "stuck_rise");
    g = 1'b0;
    cycles(100);
    g = 1'b1;
    expect_result(1'b0, 32'h0000_0000, 1'b0, 29, "stuck_high");

    // Clamping on the small instance (MAX_COUNT=999, 12-bit counter)
    g = 1'b0;
    s = 1'b0;
    cycles(3);
    pulses(999, 1, 2);
    g = 1'b1;
    expect_result(1'b1, 32'h0000_0999, 1'b0, 14, "b_at_max");
    g = 1'b0;
    pulses(1000, 1, 2);
    g = 1'b1;
    expect_result(1'b1, 32'h0000_0999, 1'b1, 14, "b_max_plus1");
    g = 1'b0;
    pulses(5000, 1, 2);
    g = 1'b1;
    expect_result(1'b1, 32'h0000_0999, 1'b1, 14, "b_saturate");
    g = 1'b0;
    pulses(42, 2, 2);
    g = 1'b1;
    expect_result(1'b1, 32'h0000_0042, 1'b0, 14, "b_ovf_clear");

    g = 1'b0;
    cycles(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
